// File: rtl/level_pkg.sv
// Shared types and default parameters for the per-user level manager.
package level_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

  localparam int unsigned DEF_ID_W        = 3;
  localparam int unsigned DEF_LVL_W       = 4;
  localparam int unsigned DEF_MAX_LEVEL   = 15;
  localparam int unsigned DEF_LOSS_DEMOTE = 1;

endpackage

// File: rtl/level_store_ram.sv
// Single-port level table: synchronous read with one cycle of latency, no reset.
module level_store_ram #(
  parameter int unsigned ID_W  = 3,
  parameter int unsigned LVL_W = 4
) (
  input  logic             clock,
  input  logic [ID_W-1:0]  address,
  input  logic [LVL_W-1:0] data,
  input  logic             wren,
  output logic [LVL_W-1:0] q
);

  localparam int unsigned DEPTH = 2 ** ID_W;

  logic [LVL_W-1:0] mem [DEPTH];

  // Write port and registered read (read-during-write returns the old word).
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/level_manager_param.sv
// Tracks the level of the logged-in user; levels live in a table that is
// initialised to 1 after every reset and persists across logins.
module level_manager_param
  import level_pkg::*;
#(
  parameter int unsigned ID_W        = DEF_ID_W,
  parameter int unsigned LVL_W       = DEF_LVL_W,
  parameter int unsigned MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter int unsigned LOSS_DEMOTE = DEF_LOSS_DEMOTE
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             auth_bit,
  input  logic [ID_W-1:0]  internal_id,
  input  logic             log_out,
  input  logic             win,
  input  logic             lose,
  output logic [LVL_W-1:0] level_num,
  output logic             levelupdated,
  output logic             max_reached,
  output logic             busy
);

  localparam logic [ID_W-1:0]  LAST_ADDR = {ID_W{1'b1}};
  localparam logic [LVL_W-1:0] MAX_LVL   = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0] ONE_LVL   = LVL_W'(1);
  localparam logic [LVL_W-1:0] ZERO_LVL  = '0;

  state_e           state, state_n;
  logic [ID_W-1:0]  clr_addr, clr_addr_n;
  logic [ID_W-1:0]  cur_id, cur_id_n;
  logic [LVL_W-1:0] level_n;
  logic             upd_n, max_n, busy_n;

  logic [ID_W-1:0]  ram_addr_c;
  logic [LVL_W-1:0] ram_data_c;
  logic             ram_wren_c;
  logic [LVL_W-1:0] ram_q;

  level_store_ram #(
    .ID_W  (ID_W),
    .LVL_W (LVL_W)
  ) u_store (
    .clock   (clock),
    .address (ram_addr_c),
    .data    (ram_data_c),
    .wren    (ram_wren_c),
    .q       (ram_q)
  );

  // State and registered outputs.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state        <= ST_CLEAR;
      clr_addr     <= '0;
      cur_id       <= '0;
      level_num    <= '0;
      levelupdated <= 1'b0;
      max_reached  <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_n;
      clr_addr     <= clr_addr_n;
      cur_id       <= cur_id_n;
      level_num    <= level_n;
      levelupdated <= upd_n;
      max_reached  <= max_n;
      busy         <= busy_n;
    end
  end

  // Next state, next output values and table access for this cycle.
  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    cur_id_n   = cur_id;
    level_n    = level_num;
    upd_n      = 1'b0;
    ram_addr_c = cur_id;
    ram_data_c = level_num;
    ram_wren_c = 1'b0;

    case (state)
      ST_CLEAR: begin
        ram_addr_c = clr_addr;
        ram_data_c = ONE_LVL;
        ram_wren_c = 1'b1;
        clr_addr_n = clr_addr + ID_W'(1);
        level_n    = ZERO_LVL;
        if (clr_addr == LAST_ADDR) begin
          state_n = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // Address follows the requested ID so the read is issued on the login edge.
        ram_addr_c = internal_id;
        if (auth_bit) begin
          cur_id_n = internal_id;
          state_n  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (log_out) begin
          state_n = ST_IDLE;
          level_n = ZERO_LVL;
        end else begin
          state_n = ST_ACTIVE;
          level_n = ram_q;
          upd_n   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (log_out) begin
          state_n = ST_IDLE;
          level_n = ZERO_LVL;
        end else if (win && !lose) begin
          if (level_num < MAX_LVL) begin
            level_n = level_num + ONE_LVL;
            upd_n   = 1'b1;
            state_n = ST_UPDATE;
          end
        end else if (lose && !win) begin
          if ((LOSS_DEMOTE != 0) && (level_num > ONE_LVL)) begin
            level_n = level_num - ONE_LVL;
            upd_n   = 1'b1;
            state_n = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        // Commit the changed level; the write completes even on logout.
        ram_wren_c = 1'b1;
        if (log_out) begin
          state_n = ST_IDLE;
          level_n = ZERO_LVL;
        end else begin
          state_n = ST_ACTIVE;
        end
      end
      default: begin
        state_n    = ST_CLEAR;
        clr_addr_n = '0;
        level_n    = ZERO_LVL;
      end
    endcase

    busy_n = (state_n == ST_CLEAR) || (state_n == ST_LOAD) || (state_n == ST_UPDATE);
    max_n  = (state_n == ST_ACTIVE) && (level_n == MAX_LVL);
  end

endmodule

// File: tb/tb_level_manager_param.sv
// Bench for level_manager_param: a default instance and a MAX_LEVEL=3 instance
// share stimulus; a table-based model is checked every cycle plus literal checks.
module tb_level_manager_param;

  localparam int NID = 8;
  localparam int M_CLEAR  = 0;
  localparam int M_IDLE   = 1;
  localparam int M_LOAD   = 2;
  localparam int M_ACTIVE = 3;
  localparam int M_UPDATE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       auth = 1'b0;
  logic [2:0] id = 3'd0;
  logic       lo = 1'b0;
  logic       w = 1'b0;
  logic       l = 1'b0;

  logic [3:0] lvl_o  [2];
  logic       upd_o  [2];
  logic       max_o  [2];
  logic       busy_o [2];

  int checks = 0;
  int errors = 0;

  int mx  [2] = '{15, 3};
  int dem [2] = '{1, 1};
  int m_mode [2];
  int m_clr  [2];
  int m_uid  [2];
  int m_lvl  [2];
  int m_pls  [2];
  int m_tbl  [2][NID];

  always #5 clk = ~clk;

  level_manager_param dut_a (
    .clock(clk), .rst(rst_n), .auth_bit(auth), .internal_id(id),
    .log_out(lo), .win(w), .lose(l),
    .level_num(lvl_o[0]), .levelupdated(upd_o[0]),
    .max_reached(max_o[0]), .busy(busy_o[0])
  );

  level_manager_param #(.ID_W(3), .LVL_W(4), .MAX_LEVEL(3), .LOSS_DEMOTE(1)) dut_b (
    .clock(clk), .rst(rst_n), .auth_bit(auth), .internal_id(id),
    .log_out(lo), .win(w), .lose(l),
    .level_num(lvl_o[1]), .levelupdated(upd_o[1]),
    .max_reached(max_o[1]), .busy(busy_o[1])
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_CLEAR;
      m_clr[k]  = NID;
      m_lvl[k]  = 0;
      m_pls[k]  = 0;
    end
  endtask

  // One clock of behaviour: the table is updated the moment a level changes.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_pls[k] = 0;
      case (m_mode[k])
        M_CLEAR: begin
          m_clr[k]--;
          if (m_clr[k] == 0) begin
            for (int i = 0; i < NID; i++) m_tbl[k][i] = 1;
            m_mode[k] = M_IDLE;
          end
        end
        M_IDLE: if (auth) begin
          m_uid[k]  = int'(id);
          m_mode[k] = M_LOAD;
        end
        M_LOAD: if (lo) begin
          m_mode[k] = M_IDLE;
          m_lvl[k]  = 0;
        end else begin
          m_lvl[k]  = m_tbl[k][m_uid[k]];
          m_pls[k]  = 1;
          m_mode[k] = M_ACTIVE;
        end
        M_ACTIVE: if (lo) begin
          m_mode[k] = M_IDLE;
          m_lvl[k]  = 0;
        end else if (w && !l && m_lvl[k] < mx[k]) begin
          m_lvl[k]++;
          m_tbl[k][m_uid[k]] = m_lvl[k];
          m_pls[k]  = 1;
          m_mode[k] = M_UPDATE;
        end else if (l && !w && dem[k] != 0 && m_lvl[k] > 1) begin
          m_lvl[k]--;
          m_tbl[k][m_uid[k]] = m_lvl[k];
          m_pls[k]  = 1;
          m_mode[k] = M_UPDATE;
        end
        M_UPDATE: if (lo) begin
          m_mode[k] = M_IDLE;
          m_lvl[k]  = 0;
        end else begin
          m_mode[k] = M_ACTIVE;
        end
        default: m_mode[k] = M_CLEAR;
      endcase
    end
  endtask

  // Model process.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of both instances against the model.
  initial begin
    #2;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc dut%0d level_num", k), int'(lvl_o[k]), m_lvl[k]);
        chk($sformatf("cyc dut%0d levelupdated", k), int'(upd_o[k]), m_pls[k]);
        chk($sformatf("cyc dut%0d max_reached", k), int'(max_o[k]),
            int'(m_mode[k] == M_ACTIVE && m_lvl[k] == mx[k]));
        chk($sformatf("cyc dut%0d busy", k), int'(busy_o[k]),
            int'(m_mode[k] == M_CLEAR || m_mode[k] == M_LOAD || m_mode[k] == M_UPDATE));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic login(input int uid);
    auth = 1'b1;
    id   = 3'(uid);
    cyc();
    auth = 1'b0;
    cyc();
  endtask

  task automatic pulse_win();
    w = 1'b1;
    cyc();
    w = 1'b0;
  endtask

  task automatic pulse_lose();
    l = 1'b1;
    cyc();
    l = 1'b0;
  endtask

  task automatic logout();
    lo = 1'b1;
    cyc();
    lo = 1'b0;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (busy_o[0] && n < 50) begin
      cyc();
      n++;
    end
    chk(nm, n, 8);
  endtask

  int ea [3] = '{2, 3, 4};
  int eb [3] = '{2, 3, 3};
  int ub [3] = '{1, 1, 0};

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("reset busy", int'(busy_o[0]), 1);
    chk("reset level", int'(lvl_o[0]), 0);
    rst_n = 1'b1;
    count_busy("busy cycles after reset");
    chk("idle level", int'(lvl_o[0]), 0);

    // Login and three wins
    login(5);
    chk("login5 level", int'(lvl_o[0]), 1);
    chk("login5 pulse", int'(upd_o[0]), 1);
    for (int i = 0; i < 3; i++) begin
      pulse_win();
      chk($sformatf("win%0d A level", i), int'(lvl_o[0]), ea[i]);
      chk($sformatf("win%0d A pulse", i), int'(upd_o[0]), 1);
      chk($sformatf("win%0d B level", i), int'(lvl_o[1]), eb[i]);
      chk($sformatf("win%0d B pulse", i), int'(upd_o[1]), ub[i]);
      cyc();
    end
    chk("B max after saturating win", int'(max_o[1]), 1);

    // Persistence across logins
    logout();
    chk("logout level", int'(lvl_o[0]), 0);
    login(2);
    chk("login2 level", int'(lvl_o[0]), 1);
    logout();
    login(5);
    chk("relogin5 A level", int'(lvl_o[0]), 4);
    chk("relogin5 B level", int'(lvl_o[1]), 3);
    cyc();

    // Saturation on B, continued climb on A
    for (int i = 0; i < 5; i++) begin
      pulse_win();
      chk("sat A level", int'(lvl_o[0]), 5 + i);
      chk("sat B level", int'(lvl_o[1]), 3);
      chk("sat B pulse", int'(upd_o[1]), 0);
      chk("sat B max", int'(max_o[1]), 1);
      cyc();
    end
    pulse_lose();
    chk("lose A level", int'(lvl_o[0]), 8);
    chk("lose B level", int'(lvl_o[1]), 2);
    cyc();
    chk("lose B max", int'(max_o[1]), 0);

    // win and lose together
    w = 1'b1; l = 1'b1;
    cyc();
    w = 1'b0; l = 1'b0;
    chk("winlose A level", int'(lvl_o[0]), 8);
    chk("winlose A pulse", int'(upd_o[0]), 0);
    chk("winlose B level", int'(lvl_o[1]), 2);

    // logout beats win
    lo = 1'b1; w = 1'b1;
    cyc();
    lo = 1'b0; w = 1'b0;
    chk("logout+win level", int'(lvl_o[0]), 0);
    chk("logout+win pulse", int'(upd_o[0]), 0);
    login(5);
    chk("relogin after logout+win A", int'(lvl_o[0]), 8);
    chk("relogin after logout+win B", int'(lvl_o[1]), 2);
    logout();

    // Lose at level 1
    login(2);
    pulse_lose();
    chk("lose at 1 level", int'(lvl_o[0]), 1);
    chk("lose at 1 pulse", int'(upd_o[0]), 0);
    cyc();
    logout();

    // Logout during LOAD
    auth = 1'b1; id = 3'd5;
    cyc();
    auth = 1'b0; lo = 1'b1;
    cyc();
    lo = 1'b0;
    chk("logout in load level", int'(lvl_o[0]), 0);
    chk("logout in load pulse", int'(upd_o[0]), 0);
    chk("logout in load busy", int'(busy_o[0]), 0);
    cyc();

    // Reset during UPDATE
    login(2);
    pulse_win();
    chk("pre-reset level", int'(lvl_o[0]), 2);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async reset dut%0d level", k), int'(lvl_o[k]), 0);
      chk($sformatf("async reset dut%0d pulse", k), int'(upd_o[k]), 0);
      chk($sformatf("async reset dut%0d max", k), int'(max_o[k]), 0);
      chk($sformatf("async reset dut%0d busy", k), int'(busy_o[k]), 1);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    count_busy("busy cycles after mid-op reset");
    for (int i = 0; i < NID; i++) begin
      login(i);
      chk($sformatf("cleared id%0d A", i), int'(lvl_o[0]), 1);
      chk($sformatf("cleared id%0d B", i), int'(lvl_o[1]), 1);
      logout();
    end
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_manager_param.md
LEVEL_MANAGER_PARAM -- requirements
Module: level_manager_param

Interface
REQ-001 Parameter ID_W, default 3: user-ID width; the table holds 2**ID_W entries.
REQ-002 Parameter LVL_W, default 4: level width.
REQ-003 Parameter MAX_LEVEL, default 15: highest level; SHALL satisfy 1 <= MAX_LEVEL <= 2**LVL_W-1.
REQ-004 Parameter LOSS_DEMOTE, default 1: 1 = a loss demotes one level; 0 = losses ignored.
REQ-005 clock  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 auth_bit  input  1  one-cycle login request for internal_id; authentication already passed.
REQ-008 internal_id  input  ID_W  user ID, sampled with auth_bit.
REQ-009 log_out  input  1  one-cycle logout of the current user.
REQ-010 win  input  1  one-cycle round-won pulse.
REQ-011 lose  input  1  one-cycle round-lost pulse.
REQ-012 level_num  output  LVL_W  current user's level; 0 when nobody is logged in.
REQ-013 levelupdated  output  1  one-cycle pulse when level_num takes a new loaded or changed value.
REQ-014 max_reached  output  1  high while ACTIVE and level_num == MAX_LEVEL.
REQ-015 busy  output  1  high in CLEAR, LOAD and UPDATE; requests are ignored while high.

Function
REQ-016 FSM states: CLEAR, IDLE, LOAD, ACTIVE, UPDATE.
REQ-017 CLEAR: write level 1 to addresses 0..2**ID_W-1, one per cycle, ascending; go to IDLE after the last write (2**ID_W cycles).
REQ-018 IDLE + auth_bit: latch internal_id, issue table read, go to LOAD; auth_bit in any other state is ignored.
REQ-019 LOAD: one cycle; the read data becomes level_num at the transition to ACTIVE; levelupdated pulses that cycle. level_num is valid 2 cycles after the auth_bit edge.
REQ-020 ACTIVE + win, level_num < MAX_LEVEL: level_num+1 written to the table and presented on level_num next cycle through UPDATE; levelupdated pulses with the new value.
REQ-021 ACTIVE + win, level_num == MAX_LEVEL: saturate; no write, no pulse, stay ACTIVE.
REQ-022 ACTIVE + lose, LOSS_DEMOTE=1, level_num > 1: decrement, write and pulse as in REQ-020.
REQ-023 Lose at level 1, or LOSS_DEMOTE=0: no change, no write, no pulse.
REQ-024 UPDATE lasts exactly one cycle, then returns to ACTIVE.
REQ-025 win and lose in the same cycle: both discarded, no change.
REQ-026 log_out in ACTIVE: go to IDLE, level_num = 0, no write, no pulse. log_out has priority over win/lose in the same cycle.
REQ-027 log_out in LOAD or UPDATE: the in-flight read or write completes, then go to IDLE without entering ACTIVE; no levelupdated.
REQ-028 The stored level SHALL always lie in 1..MAX_LEVEL; arithmetic is LVL_W bits and never wraps.
REQ-029 Table contents persist across logins until reset.

Reset
REQ-030 Asserting rst (low) asynchronously forces state CLEAR with level_num=0, levelupdated=0, max_reached=0, busy=1, and the clear address at 0.
REQ-031 Reset mid-operation (any state) SHALL abandon the current user and re-clear the whole table after release.

Structure
REQ-032 Package level_pkg holds the FSM state enum and default parameter constants.
REQ-033 One sub-module, level_store_ram: single-port, synchronous-read RAM (address, data, wren, q), depth 2**ID_W, width LVL_W, 1-cycle read latency, no reset.

Verification
REQ-034 Reset release with defaults -> busy high for exactly 8 cycles, then IDLE with level_num=0.
REQ-035 Login id=5 -> level_num=1 with levelupdated 2 cycles after auth_bit; 3 wins -> level_num 2, 3, 4, each with one pulse.
REQ-036 id=5 at 4, log_out, login id=2 -> 1; log_out, login id=5 -> 4, so the table persists.
REQ-037 MAX_LEVEL=3, 5 wins -> level_num stops at 3, max_reached=1, no further pulses; one lose -> 2, max_reached=0.
REQ-038 win and lose in the same cycle -> no change; log_out with win in the same cycle -> level_num=0, and relogin shows the pre-win level.
REQ-039 rst asserted during UPDATE -> outputs at reset values immediately; after release the full clear runs and every ID reads level 1.
